// File: rtl/mult_div_if.sv
// Control-unit handshake and HI/LO result bus for the iterative multiply/divide unit.
interface mult_div_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic             op;
  logic [WIDTH-1:0] A_in;
  logic [WIDTH-1:0] B_in;
  logic [WIDTH-1:0] HI_out;
  logic [WIDTH-1:0] LO_out;
  logic             busy;
  logic             done;
  logic             div_zero;

  modport master (
    output start, op, A_in, B_in,
    input  HI_out, LO_out, busy, done, div_zero
  );

  modport slave (
    input  start, op, A_in, B_in,
    output HI_out, LO_out, busy, done, div_zero
  );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative signed multiply (radix-2 Booth) / divide (restoring) unit, one bit per cycle,
// writing HI/LO on completion with a one-cycle done pulse.
module mult_div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic       clk,
  input  logic       reset,
  mult_div_if.slave  bus
);
  localparam int unsigned CntW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {StIdle, StMult, StDiv, StFin} state_e;

  state_e            r_state;
  state_e            w_state_next;
  logic [CntW-1:0]   r_cnt;
  logic [WIDTH-1:0]  r_hi;
  logic [WIDTH-1:0]  r_lo;
  logic              r_q1;
  logic [WIDTH-1:0]  r_mcand;
  logic              r_neg_q;
  logic              r_neg_r;
  logic              r_dz;
  logic [WIDTH-1:0]  r_hi_out;
  logic [WIDTH-1:0]  r_lo_out;

  logic              w_accept;
  logic              w_b_zero;
  logic              w_last;
  logic [WIDTH-1:0]  w_mag_a;
  logic [WIDTH-1:0]  w_mag_b;
  logic [WIDTH:0]    w_ext_hi;
  logic [WIDTH:0]    w_ext_m;
  logic [WIDTH:0]    w_booth_sum;
  logic [WIDTH-1:0]  w_mul_hi;
  logic [WIDTH-1:0]  w_mul_lo;
  logic [WIDTH:0]    w_rem_shift;
  logic [WIDTH:0]    w_diff;
  logic              w_div_ok;
  logic [WIDTH-1:0]  w_div_hi;
  logic [WIDTH-1:0]  w_div_lo;

  assign w_accept = bus.start && ((r_state == StIdle) || (r_state == StFin));
  assign w_b_zero = (bus.B_in == '0);
  assign w_last   = (r_cnt == CntW'(WIDTH - 1));
  assign w_mag_a  = bus.A_in[WIDTH-1] ? -bus.A_in : bus.A_in;
  assign w_mag_b  = bus.B_in[WIDTH-1] ? -bus.B_in : bus.B_in;

  // Booth step: add/sub on a sign-extended upper half so -2^(W-1) multiplicands cannot overflow.
  assign w_ext_hi = {r_hi[WIDTH-1], r_hi};
  assign w_ext_m  = {r_mcand[WIDTH-1], r_mcand};

  always_comb begin
    w_booth_sum = w_ext_hi;
    case ({r_lo[0], r_q1})
      2'b01:   w_booth_sum = w_ext_hi + w_ext_m;
      2'b10:   w_booth_sum = w_ext_hi - w_ext_m;
      default: w_booth_sum = w_ext_hi;
    endcase
  end

  assign w_mul_hi = w_booth_sum[WIDTH:1];
  assign w_mul_lo = {w_booth_sum[0], r_lo[WIDTH-1:1]};

  // Restoring divide step: r_hi is the partial remainder, r_lo shifts dividend out / quotient in.
  assign w_rem_shift = {r_hi, r_lo[WIDTH-1]};
  assign w_diff      = w_rem_shift - {1'b0, r_mcand};
  assign w_div_ok    = ~w_diff[WIDTH];
  assign w_div_hi    = w_div_ok ? w_diff[WIDTH-1:0] : w_rem_shift[WIDTH-1:0];
  assign w_div_lo    = {r_lo[WIDTH-2:0], w_div_ok};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle, StFin: begin
        if (bus.start) begin
          if (!bus.op)       w_state_next = StMult;
          else if (w_b_zero) w_state_next = StFin;
          else               w_state_next = StDiv;
        end else begin
          w_state_next = StIdle;
        end
      end
      StMult:  if (w_last) w_state_next = StFin;
      StDiv:   if (w_last) w_state_next = StFin;
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt    <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_q1     <= 1'b0;
      r_mcand  <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_dz     <= 1'b0;
      r_hi_out <= '0;
      r_lo_out <= '0;
    end else if (w_accept) begin
      r_cnt <= '0;
      r_hi  <= '0;
      r_q1  <= 1'b0;
      r_dz  <= bus.op && w_b_zero;
      if (!bus.op) begin
        r_lo    <= bus.B_in;
        r_mcand <= bus.A_in;
      end else begin
        r_lo    <= w_mag_a;
        r_mcand <= w_mag_b;
        r_neg_q <= bus.A_in[WIDTH-1] ^ bus.B_in[WIDTH-1];
        r_neg_r <= bus.A_in[WIDTH-1];
      end
    end else if (r_state == StMult) begin
      r_hi  <= w_mul_hi;
      r_lo  <= w_mul_lo;
      r_q1  <= r_lo[0];
      r_cnt <= r_cnt + CntW'(1);
      if (w_last) begin
        r_hi_out <= w_mul_hi;
        r_lo_out <= w_mul_lo;
      end
    end else if (r_state == StDiv) begin
      r_hi  <= w_div_hi;
      r_lo  <= w_div_lo;
      r_cnt <= r_cnt + CntW'(1);
      if (w_last) begin
        r_hi_out <= r_neg_r ? -w_div_hi : w_div_hi;
        r_lo_out <= r_neg_q ? -w_div_lo : w_div_lo;
      end
    end
  end

  // Status outputs decode only the state register, so nothing is combinational from inputs.
  assign bus.HI_out   = r_hi_out;
  assign bus.LO_out   = r_lo_out;
  assign bus.busy     = (r_state == StMult) || (r_state == StDiv);
  assign bus.done     = (r_state == StFin);
  assign bus.div_zero = (r_state == StFin) && r_dz;
endmodule

// File: tb/tb_mult_div_unit.sv
// Directed, table-driven bench for mult_div_unit plus hand sequences for overlap and reset abort.
module tb_mult_div_unit;
  localparam int unsigned W = 32;

  logic clk;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  mult_div_if #(.WIDTH(W)) bus ();

  mult_div_unit #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    logic        dz;
    string       name;
  } vec_t;

  vec_t vecs[12];

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Starts an operation now (cycle N) and checks the whole timing window.
  // Non-div-zero ops return positioned in the done cycle N+33.
  task automatic run_op(input vec_t v);
    int nb;
    int nd;
    bus.start = 1'b1;
    bus.op    = v.op;
    bus.A_in  = v.a;
    bus.B_in  = v.b;
    tick();
    bus.start = 1'b0;
    if (v.dz) begin
      chk({v.name, " done@N+1"}, {31'd0, bus.done}, 32'd1);
      chk({v.name, " div_zero@N+1"}, {31'd0, bus.div_zero}, 32'd1);
      chk({v.name, " busy@N+1"}, {31'd0, bus.busy}, 32'd0);
      tick();
      chk({v.name, " done@N+2"}, {31'd0, bus.done | bus.div_zero}, 32'd0);
      chk({v.name, " busy@N+2"}, {31'd0, bus.busy}, 32'd0);
    end else begin
      nb = 0;
      nd = 0;
      for (int k = 1; k <= 32; k++) begin
        nb += int'(bus.busy);
        nd += int'(bus.done | bus.div_zero);
        tick();
      end
      chk({v.name, " busy cycles"}, 32'(nb), 32'd32);
      chk({v.name, " early done"}, 32'(nd), 32'd0);
      chk({v.name, " done@N+33"}, {31'd0, bus.done}, 32'd1);
      chk({v.name, " busy@N+33"}, {31'd0, bus.busy}, 32'd0);
      chk({v.name, " div_zero"}, {31'd0, bus.div_zero}, 32'd0);
    end
    chk({v.name, " HI"}, bus.HI_out, v.exp_hi);
    chk({v.name, " LO"}, bus.LO_out, v.exp_lo);
  endtask

  initial begin
    vec_t v;
    int   nb;
    int   nd;

    vecs[0]  = '{1'b0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, "mul 7*-3"};
    vecs[1]  = '{1'b0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, "mul min*min"};
    vecs[2]  = '{1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0, "mul -1*-1"};
    vecs[3]  = '{1'b1, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, "div -7/2"};
    vecs[4]  = '{1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, "div min/-1"};
    vecs[5]  = '{1'b0, 32'd5,        32'd6,        32'h00000000, 32'd30,       1'b0, "mul 5*6"};
    vecs[6]  = '{1'b1, 32'd9,        32'd0,        32'h00000000, 32'd30,       1'b1, "div 9/0"};
    vecs[7]  = '{1'b1, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0, "div 100/7"};
    vecs[8]  = '{1'b1, 32'd100,      32'hFFFFFFF9, 32'd2,        32'hFFFFFFF2, 1'b0, "div 100/-7"};
    vecs[9]  = '{1'b0, 32'h12345678, 32'h10,       32'h00000001, 32'h23456780, 1'b0, "mul x*16"};
    vecs[10] = '{1'b1, 32'd3,        32'd5,        32'd3,        32'd0,        1'b0, "div 3/5"};
    vecs[11] = '{1'b0, 32'hFFFFFFFF, 32'h80000000, 32'h00000000, 32'h80000000, 1'b0, "mul -1*min"};

    reset     = 1'b1;
    bus.start = 1'b0;
    bus.op    = 1'b0;
    bus.A_in  = '0;
    bus.B_in  = '0;
    tick();
    tick();
    chk("reset HI", bus.HI_out, 32'd0);
    chk("reset LO", bus.LO_out, 32'd0);
    chk("reset flags", {29'd0, bus.busy, bus.done, bus.div_zero}, 32'd0);
    reset = 1'b0;
    tick();

    foreach (vecs[i]) begin
      run_op(vecs[i]);
      tick();
    end

    // Stray start mid-operation is ignored; start in the done cycle chains the next op.
    v = '{1'b0, 32'd7, 32'hFFFFFFFD, 32'h0, 32'h0, 1'b0, "overlap"};
    bus.start = 1'b1;
    bus.op    = v.op;
    bus.A_in  = v.a;
    bus.B_in  = v.b;
    tick();
    bus.start = 1'b0;
    nb = 0;
    nd = 0;
    for (int k = 1; k <= 32; k++) begin
      if (k == 5) begin
        bus.start = 1'b1;
        bus.op    = 1'b1;
        bus.A_in  = 32'd1;
        bus.B_in  = 32'd0;
      end
      if (k == 6) bus.start = 1'b0;
      nb += int'(bus.busy);
      nd += int'(bus.done | bus.div_zero);
      tick();
    end
    chk("overlap busy cycles", 32'(nb), 32'd32);
    chk("overlap early done", 32'(nd), 32'd0);
    chk("overlap first done", {31'd0, bus.done}, 32'd1);
    chk("overlap first HI", bus.HI_out, 32'hFFFFFFFF);
    chk("overlap first LO", bus.LO_out, 32'hFFFFFFEB);
    run_op('{1'b0, 32'd3, 32'd5, 32'd0, 32'd15, 1'b0, "chained 3*5"});
    tick();

    // Reset during a divide aborts it with no done pulse.
    bus.start = 1'b1;
    bus.op    = 1'b1;
    bus.A_in  = 32'd100;
    bus.B_in  = 32'd7;
    tick();
    bus.start = 1'b0;
    for (int k = 1; k < 10; k++) tick();
    chk("pre-abort busy", {31'd0, bus.busy}, 32'd1);
    reset = 1'b1;
    tick();
    chk("abort HI", bus.HI_out, 32'd0);
    chk("abort LO", bus.LO_out, 32'd0);
    chk("abort flags", {29'd0, bus.busy, bus.done, bus.div_zero}, 32'd0);
    reset = 1'b0;
    nd = 0;
    for (int k = 0; k < 30; k++) begin
      nd += int'(bus.done | bus.busy);
      tick();
    end
    chk("abort no done", 32'(nd), 32'd0);
    run_op('{1'b0, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0, "post-reset 3*4"});
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
